// File: rtl/bn_stats.sv
// bn_stats: streaming window statistics for the batch-norm stage.
//
// Accepts one signed sample per in_valid/in_ready handshake and accumulates
// the sum and sum-of-squares over a window of HEIGHT*WIDTH samples. When the
// window is full, the block stops accepting samples. A shared restoring
// divider then produces trunc(sum/N) and floor(sumsq/N), one quotient bit per
// cycle. A final cycle forms the clamped variance and publishes mean and
// variance.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset; aborts any window in flight
//   in_valid     sample present on data
//   data         signed sample, BITWIDTH bits
//   in_ready     high while collecting; a sample is taken on in_valid&&in_ready
//   mean         signed window mean (truncated toward zero), held between updates
//   variance     window variance, clamped to [0, 2^(BITWIDTH-1)-1], held
//                between updates ('var' is a reserved word in SystemVerilog)
//   stats_valid  one-cycle pulse in the cycle mean/variance take new values
//   busy         high while dividing or finalising
module bn_stats #(
    parameter int BITWIDTH = 32,
    parameter int HEIGHT   = 1,
    parameter int WIDTH    = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic signed [BITWIDTH-1:0] data,
    output logic                       in_ready,
    output logic signed [BITWIDTH-1:0] mean,
    output logic signed [BITWIDTH-1:0] variance,
    output logic                       stats_valid,
    output logic                       busy
);

    localparam int N   = HEIGHT * WIDTH;
    localparam int SW  = BITWIDTH + 8;
    localparam int QW  = 2 * BITWIDTH + 8;
    // The remainder is always below N <= 256, so 8 bits hold it.
    localparam int RMW = 8;
    localparam int CW  = 9;

    localparam logic [RMW:0]          DIVISOR    = (RMW + 1)'(N);
    localparam logic [CW-1:0]         LAST_COUNT = CW'(N - 1);
    localparam logic [CW-1:0]         MEAN_LAST  = CW'(SW - 1);
    localparam logic [CW-1:0]         SQ_LAST    = CW'(QW - 1);
    localparam logic [BITWIDTH-1:0]   VAR_MAX    = {1'b0, {(BITWIDTH - 1){1'b1}}};

    typedef enum logic [1:0] {
        COLLECT,
        DIV_MEAN,
        DIV_SQ,
        FINAL
    } state_t;

    state_t state;
    state_t state_next;

    logic signed [SW-1:0]         sum;
    logic [QW-1:0]                sumsq;
    logic [CW-1:0]                count;
    logic [CW-1:0]                step;
    logic [QW-1:0]                div_quo;
    logic [RMW-1:0]               div_rem;
    logic                         sum_neg;
    logic signed [BITWIDTH-1:0]   mean_q;
    logic [QW-1:0]                sq_q;

    logic                         accept;
    logic                         last_sample;
    logic signed [2*BITWIDTH-1:0] square;
    logic signed [SW-1:0]         sum_next;
    logic [QW-1:0]                sumsq_next;
    logic [SW-1:0]                sum_mag;
    logic [RMW:0]                 rem_shift;
    logic                         quo_bit;
    logic [QW-1:0]                quo_step;
    logic [BITWIDTH-1:0]          mean_mag;
    logic signed [BITWIDTH-1:0]   mean_new;
    logic signed [2*BITWIDTH-1:0] mean_square;
    logic [QW:0]                  var_diff;
    logic signed [BITWIDTH-1:0]   var_new;

    assign in_ready    = (state == COLLECT);
    assign busy        = (state != COLLECT);
    assign accept      = in_valid && in_ready;
    assign last_sample = accept && (count == LAST_COUNT);

    // Accumulator updates including the sample being accepted this cycle, so
    // the divider can be loaded with the complete window on the last accept.
    assign square     = data * data;
    assign sum_next   = sum + {{(SW - BITWIDTH){data[BITWIDTH-1]}}, data};
    assign sumsq_next = sumsq + {{(QW - 2 * BITWIDTH){1'b0}}, square};
    assign sum_mag    = sum_next[SW-1] ? (~sum_next + 1'b1) : sum_next;

    // One restoring-division step: the dividend shifts out of the top of
    // div_quo while quotient bits shift in at the bottom.
    assign rem_shift = {div_rem, div_quo[QW-1]};
    assign quo_bit   = (rem_shift >= DIVISOR);
    assign quo_step  = {div_quo[QW-2:0], quo_bit};

    // The mean magnitude never exceeds 2^(BITWIDTH-1), so the low bits of
    // the quotient are enough to apply the sign.
    assign mean_mag = quo_step[BITWIDTH-1:0];
    assign mean_new = sum_neg ? (~mean_mag + 1'b1) : mean_mag;

    // Variance in QW+1 bits so a negative difference is visible in the MSB.
    assign mean_square = mean_q * mean_q;
    assign var_diff    = {1'b0, sq_q} - {{(QW + 1 - 2 * BITWIDTH){1'b0}}, mean_square};

    always_comb begin
        var_new = var_diff[BITWIDTH-1:0];
        if (var_diff[QW]) begin
            var_new = '0;
        end else if (var_diff[QW-1:0] > {{(QW - BITWIDTH){1'b0}}, VAR_MAX}) begin
            var_new = VAR_MAX;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= COLLECT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            COLLECT:  if (last_sample) state_next = DIV_MEAN;
            DIV_MEAN: if (step == MEAN_LAST) state_next = DIV_SQ;
            DIV_SQ:   if (step == SQ_LAST) state_next = FINAL;
            FINAL:    state_next = COLLECT;
            default:  state_next = COLLECT;
        endcase
    end

    // |sum| is loaded left-aligned so that the first SW steps consume exactly
    // its bits; the sum-of-squares then uses the full QW width.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum         <= '0;
            sumsq       <= '0;
            count       <= '0;
            step        <= '0;
            div_quo     <= '0;
            div_rem     <= '0;
            sum_neg     <= 1'b0;
            mean_q      <= '0;
            sq_q        <= '0;
            mean        <= '0;
            variance    <= '0;
            stats_valid <= 1'b0;
        end else begin
            stats_valid <= 1'b0;
            case (state)
                COLLECT: begin
                    if (accept) begin
                        sum   <= sum_next;
                        sumsq <= sumsq_next;
                        count <= count + 1'b1;
                        if (last_sample) begin
                            div_quo <= {sum_mag, {(QW - SW){1'b0}}};
                            div_rem <= '0;
                            step    <= '0;
                            sum_neg <= sum_next[SW-1];
                        end
                    end
                end
                DIV_MEAN: begin
                    div_quo <= quo_step;
                    div_rem <= RMW'(quo_bit ? rem_shift - DIVISOR : rem_shift);
                    step    <= step + 1'b1;
                    if (step == MEAN_LAST) begin
                        mean_q  <= mean_new;
                        div_quo <= sumsq;
                        div_rem <= '0;
                        step    <= '0;
                    end
                end
                DIV_SQ: begin
                    div_quo <= quo_step;
                    div_rem <= RMW'(quo_bit ? rem_shift - DIVISOR : rem_shift);
                    step    <= step + 1'b1;
                    if (step == SQ_LAST) begin
                        sq_q <= quo_step;
                    end
                end
                FINAL: begin
                    mean        <= mean_q;
                    variance    <= var_new;
                    stats_valid <= 1'b1;
                    sum         <= '0;
                    sumsq       <= '0;
                    count       <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bn_stats.sv
// tb_bn_stats: self-checking bench for bn_stats (BITWIDTH=32, N=5).
// Windows are streamed through the handshake and the published mean/variance
// are compared against a wide-integer model of the window statistics.
module tb_bn_stats;

    localparam int N   = 5;
    localparam int LAT = 113;

    typedef logic signed [31:0] win_t [5];

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic signed [31:0] data;
    logic               in_ready;
    logic signed [31:0] mean;
    logic signed [31:0] variance;
    logic               stats_valid;
    logic               busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bn_stats dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .data        (data),
        .in_ready    (in_ready),
        .mean        (mean),
        .variance    (variance),
        .stats_valid (stats_valid),
        .busy        (busy)
    );

    function automatic logic signed [127:0] ext(input logic signed [31:0] x);
        return $signed({{96{x[31]}}, x});
    endfunction

    // Mean truncates toward zero (signed division), mean-of-squares floors,
    // variance is clamped to the positive 32-bit range.
    function automatic void model(input win_t s, output logic signed [31:0] em,
                                  output logic signed [31:0] ev);
        logic signed [127:0] sum;
        logic signed [127:0] sq;
        logic signed [127:0] m;
        logic signed [127:0] v;
        sum = '0;
        sq  = '0;
        for (int i = 0; i < N; i++) begin
            sum = sum + ext(s[i]);
            sq  = sq + ext(s[i]) * ext(s[i]);
        end
        m = sum / 128'sd5;
        v = sq / 128'sd5 - m * m;
        if (v < 0) v = '0;
        if (v > 128'sd2147483647) v = 128'sd2147483647;
        em = m[31:0];
        ev = v[31:0];
    endfunction

    task automatic push_sample(input logic signed [31:0] d, output bit ok);
        @(negedge clk);
        in_valid = 1'b1;
        data     = d;
        for (int t = 0; t < 400 && !in_ready; t++) @(negedge clk);
        ok = in_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic run_window(input win_t s, input bit gaps, input bit hold,
                              input logic signed [31:0] hold_data, output bit ok,
                              output int lat, output logic busy_k, output logic ready_k,
                              output logic signed [31:0] mid_mean,
                              output logic signed [31:0] mid_var);
        bit pok;
        ok       = 1'b1;
        lat      = -1;
        mid_mean = '0;
        mid_var  = '0;
        for (int i = 0; i < N; i++) begin
            if (gaps && i > 0) begin
                @(negedge clk);
                in_valid = 1'b0;
            end
            push_sample(s[i], pok);
            if (!pok) ok = 1'b0;
            if (i == 0) begin
                mid_mean = mean;
                mid_var  = variance;
            end
        end
        busy_k  = busy;
        ready_k = in_ready;
        if (hold) data = hold_data;
        else in_valid = 1'b0;
        for (int t = 1; t <= 300 && lat < 0; t++) begin
            @(posedge clk);
            #1;
            if (stats_valid) lat = t;
        end
    endtask

    task automatic test_reset;
        rst      = 1'b1;
        in_valid = 1'b0;
        data     = '0;
        #2;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready got %b expected 1", in_ready); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b expected 0", busy); end
        checks++;
        if (stats_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_stats_valid got %b expected 0", stats_valid); end
        checks++;
        if (mean !== 32'sd0) begin errors++; $display("[TB] FAIL reset_mean got %0d expected 0", mean); end
        checks++;
        if (variance !== 32'sd0) begin errors++; $display("[TB] FAIL reset_var got %0d expected 0", variance); end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic;
        win_t s = '{32'sd1, 32'sd2, 32'sd3, 32'sd4, 32'sd5};
        logic signed [31:0] em, ev, mm, mv;
        logic bk, rk;
        bit ok;
        int lat;
        model(s, em, ev);
        run_window(s, 1'b0, 1'b0, '0, ok, lat, bk, rk, mm, mv);
        checks++;
        if (!ok || lat !== LAT) begin errors++; $display("[TB] FAIL basic_latency got %0d expected %0d", lat, LAT); end
        checks++;
        if (bk !== 1'b1 || rk !== 1'b0) begin errors++; $display("[TB] FAIL basic_busy got busy=%b ready=%b expected 1/0", bk, rk); end
        checks++;
        if (mean !== em) begin errors++; $display("[TB] FAIL basic_mean got %0d expected %0d", mean, em); end
        checks++;
        if (variance !== ev) begin errors++; $display("[TB] FAIL basic_var got %0d expected %0d", variance, ev); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL basic_ready_on_pulse got %b expected 1", in_ready); end
        @(posedge clk);
        #1;
        checks++;
        if (stats_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_pulse_width got %b expected 0", stats_valid); end
        checks++;
        if (mean !== em || variance !== ev) begin errors++; $display("[TB] FAIL basic_hold got %0d/%0d expected %0d/%0d", mean, variance, em, ev); end
    endtask

    task automatic test_values(input win_t s, input bit gaps, input string name);
        logic signed [31:0] em, ev, mm, mv;
        logic bk, rk;
        bit ok;
        int lat;
        model(s, em, ev);
        run_window(s, gaps, 1'b0, '0, ok, lat, bk, rk, mm, mv);
        checks++;
        if (!ok || lat !== LAT) begin errors++; $display("[TB] FAIL %s_latency got %0d expected %0d", name, lat, LAT); end
        checks++;
        if (mean !== em) begin errors++; $display("[TB] FAIL %s_mean got %0d expected %0d", name, mean, em); end
        checks++;
        if (variance !== ev) begin errors++; $display("[TB] FAIL %s_var got %0d expected %0d", name, variance, ev); end
    endtask

    task automatic test_negative;
        test_values('{-32'sd1, -32'sd2, -32'sd3, -32'sd4, -32'sd6}, 1'b0, "negative");
    endtask

    task automatic test_extremes;
        test_values('{32'sh7fffffff, 32'sh80000000, 32'sh7fffffff, 32'sh80000000, 32'sd0}, 1'b0, "saturate");
        test_values('{32'sh80000000, 32'sh80000000, 32'sh80000000, 32'sh80000000, 32'sh80000000}, 1'b0, "min_mean");
    endtask

    task automatic test_handshake;
        test_values('{32'sd7, 32'sd7, 32'sd7, 32'sd7, 32'sd7}, 1'b1, "gapped");
    endtask

    task automatic test_busy_ignored;
        win_t a = '{32'sd1, 32'sd2, 32'sd3, 32'sd4, 32'sd5};
        win_t b = '{32'sd999, 32'sd1, 32'sd1, 32'sd1, 32'sd1};
        logic signed [31:0] em, ev, mm, mv;
        logic bk, rk;
        bit ok;
        int lat;
        run_window(a, 1'b0, 1'b1, 32'sd999, ok, lat, bk, rk, mm, mv);
        checks++;
        if (!ok || lat !== LAT) begin errors++; $display("[TB] FAIL held_valid_latency got %0d expected %0d", lat, LAT); end
        model(b, em, ev);
        run_window(b, 1'b0, 1'b0, '0, ok, lat, bk, rk, mm, mv);
        checks++;
        if (mean !== em || variance !== ev) begin errors++; $display("[TB] FAIL held_valid_next got %0d/%0d expected %0d/%0d", mean, variance, em, ev); end
    endtask

    task automatic test_back_to_back;
        win_t a = '{32'sd1, 32'sd2, 32'sd3, 32'sd4, 32'sd5};
        win_t b = '{32'sd10, 32'sd10, 32'sd10, 32'sd10, 32'sd10};
        logic signed [31:0] ema, eva, emb, evb, mm, mv;
        logic bk, rk;
        bit ok;
        int lat;
        model(a, ema, eva);
        model(b, emb, evb);
        run_window(a, 1'b0, 1'b0, '0, ok, lat, bk, rk, mm, mv);
        checks++;
        if (mean !== ema || variance !== eva) begin errors++; $display("[TB] FAIL b2b_first got %0d/%0d expected %0d/%0d", mean, variance, ema, eva); end
        run_window(b, 1'b0, 1'b0, '0, ok, lat, bk, rk, mm, mv);
        checks++;
        if (mm !== ema || mv !== eva) begin errors++; $display("[TB] FAIL b2b_hold got %0d/%0d expected %0d/%0d", mm, mv, ema, eva); end
        checks++;
        if (!ok || lat !== LAT) begin errors++; $display("[TB] FAIL b2b_latency got %0d expected %0d", lat, LAT); end
        checks++;
        if (mean !== emb || variance !== evb) begin errors++; $display("[TB] FAIL b2b_second got %0d/%0d expected %0d/%0d", mean, variance, emb, evb); end
    endtask

    task automatic test_reset_mid;
        win_t a = '{32'sd1, 32'sd2, 32'sd3, 32'sd4, 32'sd5};
        bit ok;
        for (int i = 0; i < N; i++) push_sample(a[i], ok);
        in_valid = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (mean !== 32'sd0 || variance !== 32'sd0) begin errors++; $display("[TB] FAIL midreset_outputs got %0d/%0d expected 0/0", mean, variance); end
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || stats_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset_flags got ready=%b busy=%b sv=%b expected 1/0/0", in_ready, busy, stats_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        test_values('{32'sd2, 32'sd2, 32'sd2, 32'sd2, 32'sd2}, 1'b0, "after_reset");
    endtask

    task automatic test_random;
        win_t s;
        for (int w = 0; w < 8; w++) begin
            for (int i = 0; i < N; i++) begin
                case ($urandom_range(2, 0))
                    0: s[i] = $urandom();
                    1: s[i] = $signed($urandom_range(200, 0)) - 100;
                    default: s[i] = ($urandom_range(1, 0) == 1) ? 32'sh7fffffff : 32'sh80000000;
                endcase
            end
            test_values(s, $urandom_range(1, 0) == 1, "random");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_negative();
        test_extremes();
        test_handshake();
        test_busy_ignored();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
